// File: rtl/rgbled_pwm_axil.sv
// rgbled_pwm_axil: AXI4-Lite slave driving NUM_CH RGB LEDs with per-channel
// PWM brightness, per-channel blink, a global prescaler and output polarity.
// Duty values are shadowed and only change at PWM period boundaries.
module rgbled_pwm_axil #(
  parameter int NUM_CH     = 2,
  parameter int PWM_WIDTH  = 8,
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    s00_axi_aclk,
  input  logic                    s00_axi_areset,
  input  logic [ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [2:0]              s00_axi_awprot,
  input  logic                    s00_axi_awvalid,
  output logic                    s00_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                    s00_axi_wvalid,
  output logic                    s00_axi_wready,
  output logic [1:0]              s00_axi_bresp,
  output logic                    s00_axi_bvalid,
  input  logic                    s00_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [2:0]              s00_axi_arprot,
  input  logic                    s00_axi_arvalid,
  output logic                    s00_axi_arready,
  output logic [DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]              s00_axi_rresp,
  output logic                    s00_axi_rvalid,
  input  logic                    s00_axi_rready,
  output logic [NUM_CH-1:0]       led_r,
  output logic [NUM_CH-1:0]       led_g,
  output logic [NUM_CH-1:0]       led_b
);

  localparam int IDX_W = ADDR_WIDTH - 2;
  localparam logic [PWM_WIDTH-1:0] CNT_MAX = PWM_WIDTH'((1 << PWM_WIDTH) - 2);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic                  clk;
  logic                  rst;
  assign clk = s00_axi_aclk;
  assign rst = s00_axi_areset;

  // Bus-side registers
  logic                  r_wr_rdy;
  logic                  r_bvalid;
  logic [1:0]            r_bresp;
  logic                  r_arready;
  logic                  r_rvalid;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [1:0]            r_rresp;

  // Programmable registers
  logic [1:0]            r_ctrl;
  logic [15:0]           r_prescale;
  logic [15:0]           r_blink;
  logic [PWM_WIDTH-1:0]  r_col_r [NUM_CH];
  logic [PWM_WIDTH-1:0]  r_col_g [NUM_CH];
  logic [PWM_WIDTH-1:0]  r_col_b [NUM_CH];
  logic [NUM_CH-1:0]     r_blen;

  // Shadow duty, counters and outputs
  logic [PWM_WIDTH-1:0]  r_sh_r [NUM_CH];
  logic [PWM_WIDTH-1:0]  r_sh_g [NUM_CH];
  logic [PWM_WIDTH-1:0]  r_sh_b [NUM_CH];
  logic [15:0]           r_pcnt;
  logic [PWM_WIDTH-1:0]  r_cnt;
  logic [15:0]           r_bcnt;
  logic                  r_phase;
  logic [NUM_CH-1:0]     r_led_r;
  logic [NUM_CH-1:0]     r_led_g;
  logic [NUM_CH-1:0]     r_led_b;

  logic [IDX_W-1:0]      w_widx;
  logic [IDX_W-1:0]      w_ridx;
  logic                  w_wr_hs;
  logic                  w_rd_hs;
  logic                  w_wr_ok;
  logic [NUM_CH-1:0]     w_wr_col;
  logic [DATA_WIDTH-1:0] w_rdata;
  logic [1:0]            w_rresp;
  logic                  w_en;
  logic                  w_inv;
  logic                  w_tick;
  logic                  w_wrap;
  logic [NUM_CH-1:0]     w_on_r;
  logic [NUM_CH-1:0]     w_on_g;
  logic [NUM_CH-1:0]     w_on_b;
  logic                  w_unused;

  assign w_widx  = s00_axi_awaddr[ADDR_WIDTH-1:2];
  assign w_ridx  = s00_axi_araddr[ADDR_WIDTH-1:2];
  assign w_wr_hs = r_wr_rdy && s00_axi_awvalid && s00_axi_wvalid;
  assign w_rd_hs = r_arready && s00_axi_arvalid;
  assign w_en    = r_ctrl[0];
  assign w_inv   = r_ctrl[1];
  assign w_tick  = w_en && (r_pcnt >= r_prescale);
  assign w_wrap  = w_tick && (r_cnt == CNT_MAX);
  assign w_unused = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0],
                      s00_axi_araddr[1:0], s00_axi_wdata};

  assign s00_axi_awready = r_wr_rdy;
  assign s00_axi_wready  = r_wr_rdy;
  assign s00_axi_bvalid  = r_bvalid;
  assign s00_axi_bresp   = r_bresp;
  assign s00_axi_arready = r_arready;
  assign s00_axi_rvalid  = r_rvalid;
  assign s00_axi_rdata   = r_rdata;
  assign s00_axi_rresp   = r_rresp;
  assign led_r = r_led_r;
  assign led_g = r_led_g;
  assign led_b = r_led_b;

  // Write address decode: which register (if any) the pending write targets
  always_comb begin
    w_wr_col = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_wr_col[k] = (int'(w_widx) == 4 + k);
    end
    w_wr_ok = (int'(w_widx) < 4 + NUM_CH);
  end

  // Read mux: current register contents, SLVERR for unmapped words
  always_comb begin
    w_rdata = '0;
    w_rresp = RESP_SLVERR;
    if (w_ridx == IDX_W'(0)) begin
      w_rdata[1:0] = r_ctrl;
      w_rresp      = RESP_OKAY;
    end else if (w_ridx == IDX_W'(1)) begin
      w_rdata[15:0] = r_prescale;
      w_rresp       = RESP_OKAY;
    end else if (w_ridx == IDX_W'(2)) begin
      w_rdata[15:0] = r_blink;
      w_rresp       = RESP_OKAY;
    end else if (w_ridx == IDX_W'(3)) begin
      w_rdata[7:0]  = 8'(NUM_CH);
      w_rdata[15:8] = 8'(PWM_WIDTH);
      w_rresp       = RESP_OKAY;
    end
    for (int k = 0; k < NUM_CH; k++) begin
      if (int'(w_ridx) == 4 + k) begin
        w_rdata[0+:PWM_WIDTH]  = r_col_r[k];
        w_rdata[8+:PWM_WIDTH]  = r_col_g[k];
        w_rdata[16+:PWM_WIDTH] = r_col_b[k];
        w_rdata[24]            = r_blen[k];
        w_rresp                = RESP_OKAY;
      end
    end
  end

  // Write channel: one-cycle ready pulse, response held until bready
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_rdy <= 1'b0;
      r_bvalid <= 1'b0;
      r_bresp  <= RESP_OKAY;
    end else begin
      r_wr_rdy <= s00_axi_awvalid && s00_axi_wvalid && !r_bvalid && !r_wr_rdy;
      if (w_wr_hs) begin
        r_bvalid <= 1'b1;
        r_bresp  <= w_wr_ok ? RESP_OKAY : RESP_SLVERR;
      end else if (r_bvalid && s00_axi_bready) begin
        r_bvalid <= 1'b0;
      end
    end
  end

  // Read channel: one-cycle arready pulse, data captured and held until rready
  always_ff @(posedge clk) begin
    if (rst) begin
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= RESP_OKAY;
    end else begin
      r_arready <= s00_axi_arvalid && !r_rvalid && !r_arready;
      if (w_rd_hs) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rdata;
        r_rresp  <= w_rresp;
      end else if (r_rvalid && s00_axi_rready) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  // Register file update on write handshake, byte strobes honoured
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ctrl     <= '0;
      r_prescale <= '0;
      r_blink    <= '0;
      r_blen     <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        r_col_r[k] <= '0;
        r_col_g[k] <= '0;
        r_col_b[k] <= '0;
      end
    end else if (w_wr_hs) begin
      if (w_widx == IDX_W'(0) && s00_axi_wstrb[0]) r_ctrl <= s00_axi_wdata[1:0];
      if (w_widx == IDX_W'(1)) begin
        if (s00_axi_wstrb[0]) r_prescale[7:0]  <= s00_axi_wdata[7:0];
        if (s00_axi_wstrb[1]) r_prescale[15:8] <= s00_axi_wdata[15:8];
      end
      if (w_widx == IDX_W'(2)) begin
        if (s00_axi_wstrb[0]) r_blink[7:0]  <= s00_axi_wdata[7:0];
        if (s00_axi_wstrb[1]) r_blink[15:8] <= s00_axi_wdata[15:8];
      end
      for (int k = 0; k < NUM_CH; k++) begin
        if (w_wr_col[k]) begin
          if (s00_axi_wstrb[0]) r_col_r[k] <= s00_axi_wdata[0+:PWM_WIDTH];
          if (s00_axi_wstrb[1]) r_col_g[k] <= s00_axi_wdata[8+:PWM_WIDTH];
          if (s00_axi_wstrb[2]) r_col_b[k] <= s00_axi_wdata[16+:PWM_WIDTH];
          if (s00_axi_wstrb[3]) r_blen[k]  <= s00_axi_wdata[24];
        end
      end
    end
  end

  // Prescaler, PWM period counter and blink phase; all parked at 0 while disabled
  always_ff @(posedge clk) begin
    if (rst || !w_en) begin
      r_pcnt  <= '0;
      r_cnt   <= '0;
      r_bcnt  <= '0;
      r_phase <= 1'b0;
    end else begin
      r_pcnt <= w_tick ? 16'd0 : r_pcnt + 16'd1;
      if (w_tick) r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
      if (w_wrap) begin
        if (r_bcnt >= r_blink) begin
          r_bcnt  <= '0;
          r_phase <= (r_blink != 16'd0) && !r_phase;
        end else begin
          r_bcnt <= r_bcnt + 16'd1;
        end
      end
    end
  end

  // Shadow duty: tracks COLOR while disabled, otherwise latched at period wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_CH; k++) begin
        r_sh_r[k] <= '0;
        r_sh_g[k] <= '0;
        r_sh_b[k] <= '0;
      end
    end else if (!w_en || w_wrap) begin
      for (int k = 0; k < NUM_CH; k++) begin
        r_sh_r[k] <= r_col_r[k];
        r_sh_g[k] <= r_col_g[k];
        r_sh_b[k] <= r_col_b[k];
      end
    end
  end

  // Per-channel compare, enable and blink gating before polarity
  always_comb begin
    w_on_r = '0;
    w_on_g = '0;
    w_on_b = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_on_r[k] = (r_cnt < r_sh_r[k]) && w_en && !(r_blen[k] && r_phase);
      w_on_g[k] = (r_cnt < r_sh_g[k]) && w_en && !(r_blen[k] && r_phase);
      w_on_b[k] = (r_cnt < r_sh_b[k]) && w_en && !(r_blen[k] && r_phase);
    end
  end

  // Registered LED outputs with polarity applied
  always_ff @(posedge clk) begin
    if (rst) begin
      r_led_r <= '0;
      r_led_g <= '0;
      r_led_b <= '0;
    end else begin
      r_led_r <= w_on_r ^ {NUM_CH{w_inv}};
      r_led_g <= w_on_g ^ {NUM_CH{w_inv}};
      r_led_b <= w_on_b ^ {NUM_CH{w_inv}};
    end
  end

endmodule

// File: doc/rgbled_pwm_axil.md
Name: rgbled_pwm_axil

Overview:
- AXI4-Lite slave driving NUM_CH tri-colour LEDs with per-channel PWM brightness, optional blink, global prescaler and polarity control.
- Generalised successor of the 4-register rgbled peripheral. Sits behind the PS7 GP0 interconnect; led_* outputs go straight to package pins.
- Duty values are shadowed and take effect only at PWM period boundaries, so outputs never glitch.

Parameters:
- NUM_CH, 2, number of RGB channels (1..16)
- PWM_WIDTH, 8, PWM counter/duty width in bits (1..8)
- ADDR_WIDTH, 7, AXI address width; must cover 0x10+4*NUM_CH
- DATA_WIDTH, 32, AXI data width (fixed 32)

Ports:
- s00_axi_aclk  in  1  clock
- s00_axi_areset  in  1  synchronous active-high reset
- s00_axi_awaddr / awprot / awvalid / awready  in/in/in/out  ADDR_WIDTH/3/1/1  write address channel
- s00_axi_wdata / wstrb / wvalid / wready  in/in/in/out  32/4/1/1  write data channel
- s00_axi_bresp / bvalid / bready  out/out/in  2/1/1  write response channel
- s00_axi_araddr / arprot / arvalid / arready  in/in/in/out  ADDR_WIDTH/3/1/1  read address channel
- s00_axi_rdata / rresp / rvalid / rready  out/out/out/in  32/2/1/1  read data channel
- led_r, led_g, led_b  out  NUM_CH each  PWM outputs, bit k = channel k

Behaviour:
- Register map (word aligned; addr[1:0] ignored):
  - 0x00 CTRL: [0] enable, [1] invert; other bits RO 0. Reset 0.
  - 0x04 PRESCALE: [15:0]; tick every PRESCALE+1 clocks. Reset 0.
  - 0x08 BLINK: [15:0]; blink half-period in PWM periods. Reset 0.
  - 0x0C INFO: RO; [7:0]=NUM_CH, [15:8]=PWM_WIDTH. Writes ignored, OKAY.
  - 0x10+4k COLOR_k: [7:0] R, [15:8] G, [23:16] B (low PWM_WIDTH bits stored, rest read 0); [24] blink_en. Reset 0.
  - Any other address: write discarded, BRESP=SLVERR (2'b10); read RDATA=0, RRESP=SLVERR.
- WSTRB honoured per byte.
- Write handshake:
  - When awvalid && wvalid && !bvalid && !awready: awready and wready pulse high together for exactly one cycle. The register updates on that edge.
  - bvalid rises the next cycle and holds until bready.
  - AW-only or W-only is not accepted; the master holds valid.
- Read handshake:
  - When arvalid && !rvalid && !arready: arready pulses for one cycle.
  - rvalid with rdata/rresp asserts the next cycle and holds, stable, until rready.
  - Read and write channels are independent. A read accepted in the same cycle as a write to the same register returns the pre-write value.
- Reset values: all *ready, bvalid, rvalid = 0; bresp, rresp, rdata = 0; led_* = 0 (enable=0, invert=0); all counters 0.
- Prescaler:
  - pcnt increments each clock; when pcnt >= PRESCALE, tick=1 and pcnt <= 0.
  - Lowering PRESCALE below pcnt therefore ticks on the next clock.
- PWM counter:
  - On tick, cnt counts 0..2^PWM_WIDTH-2, then wraps to 0. Period P = 2^PWM_WIDTH-1 ticks.
  - At wrap (tick && cnt==max), every COLOR field is copied into the shadow duty registers.
  - Raw output = (cnt < shadow_duty). Duty 0 = always off; duty 2^PWM_WIDTH-1 = always on.
- Blink:
  - bcnt counts PWM wraps. When bcnt >= BLINK, phase toggles and bcnt <= 0.
  - Channel with blink_en=1 is forced off while phase=1.
  - BLINK=0 with blink_en=1: phase is held 0, so no blinking.
- Output: led = (raw && enable && !(blink_en && phase)) XOR invert. Registered, 1-cycle latency from the counters.
- enable=0:
  - pcnt, cnt, bcnt and phase are held at 0; shadow duty is loaded continuously from COLOR.
  - led_* = invert for all bits.
  - Re-enabling restarts the period at cnt=0.
- Reset mid-transaction: outstanding handshakes are dropped; valid/ready are low the cycle after reset asserts. The master must re-issue.

Test Plan:
- Reset then read 0x0C -> RDATA=0x0000_0802, RRESP=0; read 0x00 -> 0.
- Write 0x10=0x0000_4080 (WSTRB=0xF), CTRL=1, PRESCALE=0 -> led_r[0] high 128 of 255 clocks, led_g[0] high 64 of 255, led_b[0] low; duty change mid-period applies only after wrap.
- COLOR_1 R=0xFF and R=0x00 -> led_r[1] constantly 1 / constantly 0 across 3 periods. Set CTRL=3 (invert) -> both levels inverted.
- BLINK=2, COLOR_0=0x0100_00FF -> led_r[0] on for 3 periods, off for 3, repeating. BLINK=0 -> steady on.
- Write 0x40 and read 0x7C -> BRESP=2'b10, RDATA=0, RRESP=2'b10; no register changes. WSTRB=0x2 to COLOR_0 changes only G.
- Hold bready/rready low for 10 cycles -> bvalid/rvalid and rdata stay stable, no further awready/arready. Assert s00_axi_areset mid-write -> all outputs return to reset values the next cycle.
